// File: rtl/pipe_spawner.sv
// pipe_spawner: scrolls a field of pipe columns across the LED playfield.
// Each column holds a valid bit and a 3-bit gap index. New columns enter at
// the right edge on every scroll tick, and a pipe is inserted every SPACING
// ticks. The pixel map and the bird-column mask are decoded combinationally
// from the column registers.
// Optional feature: define PIPE_SPAWNER_SCORE_EN to build the saturating
// pipes-passed score counter. Without it, score is tied to zero.
module pipe_spawner #(
   parameter int ROWS       = 16,
   parameter int COLS       = 16,
   parameter int SCROLL_DIV = 16,
   parameter int SPACING    = 4,
   parameter int GAP_BASE   = 4,
   parameter int GAP_H      = 4,
   parameter int BIRD_COL   = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 over,
   input  logic [2:0]           rnd,
   output logic [ROWS*COLS-1:0] pipe_map,
   output logic [ROWS-1:0]      bird_mask,
   output logic                 scroll,
   output logic                 spawn,
   output logic [7:0]           score
);

   localparam int TW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam int SW = (SPACING > 1) ? $clog2(SPACING) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(SCROLL_DIV - 1);
   localparam logic [SW-1:0] SPC_LAST  = SW'(SPACING - 1);

   logic [TW-1:0]         tick_q, tick_d;
   logic [SW-1:0]         spc_q, spc_d;
   logic [COLS-1:0]       valid_q, valid_d;
   logic [COLS-1:0][2:0]  gap_q, gap_d;
   logic                  scroll_q, scroll_d;
   logic                  spawn_q, spawn_d;

   // A pixel is lit in a valid column everywhere except inside its gap window.
   function automatic logic pixel_lit(input logic v, input logic [2:0] g, input int r);
      int lo;
      int hi;
      lo = GAP_BASE + int'(g);
      hi = lo + GAP_H - 1;
      return v && ((r < lo) || (r > hi));
   endfunction

   // Tick and spacing counters; over freezes both and suppresses the scroll.
   always_comb begin
      tick_d   = tick_q;
      spc_d    = spc_q;
      scroll_d = 1'b0;
      spawn_d  = 1'b0;
      if (!over) begin
         if (tick_q == TICK_LAST) begin
            tick_d   = '0;
            scroll_d = 1'b1;
            if (spc_q == SPC_LAST) begin
               spawn_d = 1'b1;
               spc_d   = '0;
            end else begin
               spc_d = spc_q + SW'(1);
            end
         end else begin
            tick_d = tick_q + TW'(1);
         end
      end
   end

   // Column shift: everything moves one column left, new column enters at the right.
   always_comb begin
      valid_d = valid_q;
      gap_d   = gap_q;
      if (scroll_d) begin
         for (int i = 0; i < COLS - 1; i++) begin
            valid_d[i] = valid_q[i+1];
            gap_d[i]   = gap_q[i+1];
         end
         valid_d[COLS-1] = spawn_d;
         gap_d[COLS-1]   = spawn_d ? rnd : 3'd0;
      end
   end

   // State registers and the one-cycle scroll/spawn pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_q   <= '0;
         spc_q    <= '0;
         valid_q  <= '0;
         gap_q    <= '0;
         scroll_q <= 1'b0;
         spawn_q  <= 1'b0;
      end else begin
         tick_q   <= tick_d;
         spc_q    <= spc_d;
         valid_q  <= valid_d;
         gap_q    <= gap_d;
         scroll_q <= scroll_d;
         spawn_q  <= spawn_d;
      end
   end

   assign scroll = scroll_q;
   assign spawn  = spawn_q;

   // Decode the full pixel map from the column registers.
   always_comb begin
      pipe_map = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            pipe_map[r*COLS+c] = pixel_lit(valid_q[c], gap_q[c], r);
         end
      end
   end

   // Pipe pixels in the bird's column, used for collision detection.
   always_comb begin
      bird_mask = '0;
      for (int r = 0; r < ROWS; r++) begin
         bird_mask[r] = pipe_map[r*COLS+BIRD_COL];
      end
   end

`ifdef PIPE_SPAWNER_SCORE_EN
   logic [7:0] score_q, score_d;

   // Saturating increment so the score sticks at 255.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // A pipe is passed when a valid column leaves the bird's column on a scroll.
   always_comb begin
      score_d = score_q;
      if (scroll_d && valid_q[BIRD_COL]) begin
         score_d = sat_inc(score_q);
      end
   end

   // Score register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         score_q <= 8'd0;
      end else begin
         score_q <= score_d;
      end
   end

   assign score = score_q;
`else
   assign score = 8'd0;
`endif

endmodule

// File: tb/tb_pipe_spawner.sv
// Directed testbench for pipe_spawner with default parameters.
module tb_pipe_spawner;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         over = 1'b0;
   logic [2:0]   rnd = 3'd2;
   logic [255:0] pipe_map;
   logic [15:0]  bird_mask;
   logic         scroll;
   logic         spawn;
   logic [7:0]   score;

   int ntests = 0;
   int nfail  = 0;

`ifdef PIPE_SPAWNER_SCORE_EN
   localparam logic [7:0] SC1   = 8'd1;
   localparam logic [7:0] SC254 = 8'd254;
   localparam logic [7:0] SC255 = 8'd255;
`else
   localparam logic [7:0] SC1   = 8'd0;
   localparam logic [7:0] SC254 = 8'd0;
   localparam logic [7:0] SC255 = 8'd0;
`endif

   pipe_spawner dut (
      .clk       (clk),
      .reset     (reset),
      .over      (over),
      .rnd       (rnd),
      .pipe_map  (pipe_map),
      .bird_mask (bird_mask),
      .scroll    (scroll),
      .spawn     (spawn),
      .score     (score)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          edge_n;
      logic        scr;
      logic        spn;
      logic [15:0] c15;
      logic [15:0] bird;
      logic [7:0]  sc;
   } vec_t;

   vec_t tbl[15];

   function automatic logic [15:0] colmask(input logic [255:0] m, input int c);
      logic [15:0] v;
      v = '0;
      for (int r = 0; r < 16; r++) v[r] = m[r*16+c];
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reset is raised 1ns after an edge and released 1ns after the next one,
   // so the following rising edge is edge 1.
   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int cur;
      int bad;

      tbl[0]  = '{1,   1'b0, 1'b0, 16'h0000, 16'h0000, 8'd0};
      tbl[1]  = '{15,  1'b0, 1'b0, 16'h0000, 16'h0000, 8'd0};
      tbl[2]  = '{16,  1'b1, 1'b0, 16'h0000, 16'h0000, 8'd0};
      tbl[3]  = '{17,  1'b0, 1'b0, 16'h0000, 16'h0000, 8'd0};
      tbl[4]  = '{32,  1'b1, 1'b0, 16'h0000, 16'h0000, 8'd0};
      tbl[5]  = '{48,  1'b1, 1'b0, 16'h0000, 16'h0000, 8'd0};
      tbl[6]  = '{63,  1'b0, 1'b0, 16'h0000, 16'h0000, 8'd0};
      tbl[7]  = '{64,  1'b1, 1'b1, 16'hFC3F, 16'h0000, 8'd0};
      tbl[8]  = '{65,  1'b0, 1'b0, 16'hFC3F, 16'h0000, 8'd0};
      tbl[9]  = '{80,  1'b1, 1'b0, 16'h0000, 16'h0000, 8'd0};
      tbl[10] = '{255, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'd0};
      tbl[11] = '{256, 1'b1, 1'b1, 16'hFC3F, 16'hFC3F, 8'd0};
      tbl[12] = '{271, 1'b0, 1'b0, 16'hFC3F, 16'hFC3F, 8'd0};
      tbl[13] = '{272, 1'b1, 1'b0, 16'h0000, 16'h0000, SC1};
      tbl[14] = '{273, 1'b0, 1'b0, 16'h0000, 16'h0000, SC1};

      // Reset state
      #1;
      chk("rst_map",    32'(|pipe_map), 32'd0);
      chk("rst_bird",   32'(bird_mask), 32'd0);
      chk("rst_scroll", 32'(scroll),    32'd0);
      chk("rst_spawn",  32'(spawn),     32'd0);
      chk("rst_score",  32'(score),     32'd0);

      // Scenario 1: rnd=2 held, table-driven
      rnd = 3'd2;
      do_reset();
      cur = 0;
      for (int i = 0; i < 15; i++) begin
         step(tbl[i].edge_n - cur);
         cur = tbl[i].edge_n;
         chk($sformatf("t%0d_scroll", tbl[i].edge_n), 32'(scroll), 32'(tbl[i].scr));
         chk($sformatf("t%0d_spawn",  tbl[i].edge_n), 32'(spawn),  32'(tbl[i].spn));
         chk($sformatf("t%0d_col15",  tbl[i].edge_n), 32'(colmask(pipe_map, 15)), 32'(tbl[i].c15));
         chk($sformatf("t%0d_bird",   tbl[i].edge_n), 32'(bird_mask), 32'(tbl[i].bird));
         chk($sformatf("t%0d_score",  tbl[i].edge_n), 32'(score),  32'(tbl[i].sc));
      end

      // Scenario 2: rnd changes every cycle, only the spawn-edge value counts
      do_reset();
      for (int k = 1; k <= 128; k++) begin
         rnd = (k % 2 == 1) ? 3'd3 : ((k < 100) ? 3'd7 : 3'd5);
         @(posedge clk);
         #1;
         if (k == 64) begin
            chk("tog64_spawn", 32'(spawn), 32'd1);
            chk("tog64_col15", 32'(colmask(pipe_map, 15)), 32'h87FF);
         end
         if (k == 65) chk("tog65_col15", 32'(colmask(pipe_map, 15)), 32'h87FF);
      end
      chk("tog128_col15", 32'(colmask(pipe_map, 15)), 32'hE1FF);
      chk("tog128_col11", 32'(colmask(pipe_map, 11)), 32'h87FF);

      // Scenario 3: over held for edges 41..140
      rnd = 3'd2;
      do_reset();
      step(40);
      over = 1'b1;
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         step(1);
         if (scroll || spawn || (|pipe_map)) bad++;
      end
      chk("over_window_activity", 32'(bad), 32'd0);
      over = 1'b0;
      step(7);
      chk("over_e147_scroll", 32'(scroll), 32'd0);
      step(1);
      chk("over_e148_scroll", 32'(scroll), 32'd1);
      // over on the wrap cycle wins
      step(15);
      over = 1'b1;
      step(1);
      chk("over_wrap_scroll", 32'(scroll), 32'd0);
      over = 1'b0;
      step(1);
      chk("over_e165_scroll", 32'(scroll), 32'd1);
      chk("over_e165_spawn",  32'(spawn),  32'd1);
      chk("over_e165_col15",  32'(colmask(pipe_map, 15)), 32'hFC3F);
      // freeze with a pipe on screen
      over = 1'b1;
      bad = 0;
      for (int k = 0; k < 30; k++) begin
         step(1);
         if (scroll || spawn || colmask(pipe_map, 15) != 16'hFC3F) bad++;
      end
      chk("freeze_hold", 32'(bad), 32'd0);
      over = 1'b0;
      step(15);
      chk("resume15_scroll", 32'(scroll), 32'd0);
      step(1);
      chk("resume16_scroll", 32'(scroll), 32'd1);
      chk("resume16_col14",  32'(colmask(pipe_map, 14)), 32'hFC3F);
      chk("resume16_col15",  32'(colmask(pipe_map, 15)), 32'h0000);

      // Scenario 4: asynchronous reset mid tick
      do_reset();
      step(100);
      chk("pre_rst_col13", 32'(colmask(pipe_map, 13)), 32'hFC3F);
      #3;
      reset = 1'b1;
      #1;
      chk("async_rst_map",    32'(|pipe_map), 32'd0);
      chk("async_rst_scroll", 32'(scroll),    32'd0);
      chk("async_rst_score",  32'(score),     32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(15);
      chk("post_rst15_scroll", 32'(scroll), 32'd0);
      step(1);
      chk("post_rst16_scroll", 32'(scroll), 32'd1);

      // Scenario 5: long run toward score saturation
      do_reset();
      step(16527);
      chk("sat_e16527", 32'(score), 32'(SC254));
      step(1);
      chk("sat_e16528", 32'(score), 32'(SC255));
      step(172);
      chk("sat_e16700", 32'(score), 32'(SC255));

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
